// File: rtl/spi_controller.sv
// Full-duplex SPI controller: DATA_WIDTH-bit MSB-first transfers with selectable CPOL/CPHA,
// NUM_CS active-low chip selects and a busy/valid handshake toward fabric logic.
module spi_controller #(
  parameter int DATA_WIDTH      = 12,
  parameter int DATA_CLK_PERIOD = 20,
  parameter int NUM_CS          = 2,
  parameter bit CPOL            = 1'b0,
  parameter bit CPHA            = 1'b0,
  localparam int SW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [SW-1:0]         cs_sel_in,
  input  logic                  trigger_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  busy_out,
  output logic                  chip_data_out,
  input  logic                  chip_data_in,
  output logic                  chip_clk_out,
  output logic [NUM_CS-1:0]     chip_sel_out,
  output logic [1:0]            fsm_state
);

  // Handshake: trigger_in is a level request taken only while busy_out=0; data_valid_out
  // pulses for one cycle with the new data_out, and busy_out is already low in that cycle,
  // so a request held high restarts the bus on the following edge.

  localparam int HALF  = (DATA_CLK_PERIOD / 2 < 1) ? 1 : DATA_CLK_PERIOD / 2;
  localparam int CW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int NEDGE = 2 * DATA_WIDTH;
  localparam int EW    = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [SW:0] NUM_CS_V = NUM_CS[SW:0];

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         half_cnt;
  logic [EW-1:0]         edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  tick, sel_ok, lead_edge, last_edge;
  logic                  start, edge_now, finish, sample_now, drive_now;

  assign fsm_state = state;
  assign sel_ok    = ({1'b0, cs_sel_in} < NUM_CS_V);
  assign tick      = (half_cnt == CW'(HALF - 1));
  // edge_cnt holds edges already produced, so an even count means the next edge leads.
  assign lead_edge = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EW'(NEDGE - 1));
  assign sample_now = edge_now & (lead_edge ^ CPHA);
  assign drive_now  = edge_now & (CPHA ? lead_edge : (~lead_edge & ~last_edge));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    edge_now  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (trigger_in && sel_ok) begin
          start     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          edge_now  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          edge_now = 1'b1;
          if (last_edge) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      half_cnt       <= '0;
      edge_cnt       <= '0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      chip_sel_out   <= '1;
      chip_clk_out   <= CPOL;
      chip_data_out  <= 1'b0;
      busy_out       <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      if (start) begin
        half_cnt      <= '0;
        edge_cnt      <= '0;
        rx_sh         <= '0;
        // CPHA=0 presents the MSB with CS; CPHA=1 waits for the first leading edge.
        tx_sh         <= CPHA ? data_in : (data_in << 1);
        chip_data_out <= CPHA ? 1'b0 : data_in[DATA_WIDTH-1];
        chip_sel_out  <= ~(NUM_CS'(1) << cs_sel_in);
        busy_out      <= 1'b1;
      end else if (state != IDLE) begin
        half_cnt <= tick ? '0 : half_cnt + CW'(1);
        if (edge_now) begin
          chip_clk_out <= ~chip_clk_out;
          edge_cnt     <= edge_cnt + EW'(1);
        end
        if (sample_now) rx_sh <= {rx_sh[DATA_WIDTH-2:0], chip_data_in};
        if (drive_now) begin
          chip_data_out <= tx_sh[DATA_WIDTH-1];
          tx_sh         <= tx_sh << 1;
        end
        if (finish) begin
          chip_sel_out   <= '1;
          chip_data_out  <= 1'b0;
          busy_out       <= 1'b0;
          data_out       <= rx_sh;
          data_valid_out <= 1'b1;
        end
      end
    end
  end

endmodule
